// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the number of clk cycles between consecutive selected edges of an
// asynchronous input. The input is first synchronised. Each completed interval
// is reported on dout, and new_data pulses high for one cycle when it is
// reported. If an interval is longer than the counter can hold, dout reads
// 2^WIDTH-1 and overflow is set. The first, partial interval after arming is
// discarded.
//
// Parameters:
//   WIDTH        width of the interval counter and of dout / high_time
//   SYNC_STAGES  synchroniser depth on signal_in (minimum 2)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   signal_in  asynchronous measured signal
//   enable     measurement enable, synchronous to clk
//   edge_sel   00 falling, 01 rising, 10 both, 11 none
//   new_data   one-cycle strobe: dout / overflow (/ high_time) just updated
//   dout       last measured interval in clk cycles
//   overflow   last interval saturated
//   high_time  (PERIOD_METER_HIGH_TIME_EN only) cycles with the synchronised
//              input high inside the last interval
//
// Optional feature macro: PERIOD_METER_HIGH_TIME_EN
// -----------------------------------------------------------------------------
module period_meter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal_in,
  input  logic             enable,
  input  logic [1:0]       edge_sel,
  output logic             new_data,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [WIDTH-1:0] high_time
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser, previous-sample flop and edge_sel history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic [1:0]             edge_sel_q;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      s_prev     <= 1'b0;
      edge_sel_q <= 2'b00;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_in};
      s_prev     <= s_sync;
      edge_sel_q <= edge_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge selection
  // ---------------------------------------------------------------------------
  logic rise, fall, ev, sel_change;

  assign rise       = s_sync & ~s_prev;
  assign fall       = ~s_sync & s_prev;
  assign sel_change = (edge_sel != edge_sel_q);

  always_comb begin
    case (edge_sel)
      2'b00:   ev = fall;
      2'b01:   ev = rise;
      2'b10:   ev = rise | fall;
      default: ev = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and measurement datapath
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] dout_d;
  logic             overflow_d;
  logic             new_data_d;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] high_time_d;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    dout_d     = dout;
    overflow_d = overflow;
    new_data_d = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
    hcnt_d      = hcnt_q;
    high_time_d = high_time;
`endif

    if (!enable) begin
      // Disable wins over everything, including a coincident edge.
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      hcnt_d  = '0;
`endif
    end else if (sel_change) begin
      // New edge selection: the running interval is meaningless, re-arm.
      state_d = ARM;
      cnt_d   = '0;
      sat_d   = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      hcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (ev) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            sat_d   = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
            hcnt_d  = {{(WIDTH-1){1'b0}}, s_sync};
`endif
          end
        end
        MEASURE: begin
          if (ev) begin
            // The edge cycle itself is the first cycle of the next interval.
            dout_d     = cnt_q;
            overflow_d = sat_q;
            new_data_d = 1'b1;
            cnt_d      = CNT_ONE;
            sat_d      = 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
            high_time_d = hcnt_q;
            hcnt_d      = {{(WIDTH-1){1'b0}}, s_sync};
`endif
          end else begin
            if (cnt_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
`ifdef PERIOD_METER_HIGH_TIME_EN
            if (s_sync && (hcnt_q != CNT_MAX)) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
      new_data  <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      hcnt_q    <= '0;
      high_time <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      dout      <= dout_d;
      overflow  <= overflow_d;
      new_data  <= new_data_d;
`ifdef PERIOD_METER_HIGH_TIME_EN
      hcnt_q    <= hcnt_d;
      high_time <= high_time_d;
`endif
    end
  end

endmodule
